// File: rtl/shift_sequencer.sv
// Multi-cycle shifter: captures an operand on start, applies a single-bit
// shift op once per clock for `amount` steps, then pulses done with the result.
module shift_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] in,
    input  logic [1:0]  shift,
    input  logic [3:0]  amount,
    output logic        busy,
    output logic        done,
    output logic [15:0] sout
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

    state_t      state_r, state_s;
    logic [15:0] work_r, work_s;
    logic [3:0]  count_r, count_s;
    logic [1:0]  op_r, op_s;
    logic [15:0] sout_r, sout_s;
    logic        busy_r, busy_s;
    logic        done_r, done_s;
    logic [15:0] step_s;

    function automatic logic [15:0] shift_step(input logic [15:0] v, input logic [1:0] op);
        logic [15:0] r;
        case (op)
            2'b00:   r = v;
            2'b01:   r = {v[14:0], 1'b0};
            2'b10:   r = {1'b0, v[15:1]};
            2'b11:   r = {v[15], v[15:1]};
            default: r = v;
        endcase
        return r;
    endfunction

    // next-state, datapath and output decode
    always_comb begin
        state_s = state_r;
        work_s  = work_r;
        count_s = count_r;
        op_s    = op_r;
        sout_s  = sout_r;
        step_s  = shift_step(work_r, op_r);
        case (state_r)
            IDLE: begin
                if (start) begin
                    op_s    = shift;
                    work_s  = in;
                    count_s = amount;
                    // pass-through and zero-step requests complete without shifting
                    if ((shift == 2'b00) || (amount == 4'd0)) begin
                        state_s = DONE;
                        sout_s  = in;
                    end else begin
                        state_s = SHIFT;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            SHIFT: begin
                work_s  = step_s;
                count_s = count_r - 4'd1;
                if (count_r == 4'd1) begin
                    sout_s  = step_s;
                    state_s = DONE;
                end else begin
                    state_s = SHIFT;
                end
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
        busy_s = (state_s != IDLE);
        done_s = (state_s == DONE);
    end

    // state, datapath and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
            work_r  <= 16'h0000;
            count_r <= 4'd0;
            op_r    <= 2'b00;
            sout_r  <= 16'h0000;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            work_r  <= work_s;
            count_r <= count_s;
            op_r    <= op_s;
            sout_r  <= sout_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign sout = sout_r;

endmodule

// File: tb/tb_shift_sequencer.sv
// Scoreboard bench for shift_sequencer: stimulus pushes expected results,
// a negedge monitor pops and compares on every done pulse.
module tb_shift_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [15:0] in_d = 16'h0000;
    logic [1:0]  shift_d = 2'b00;
    logic [3:0]  amount_d = 4'd0;
    logic        busy;
    logic        done;
    logic [15:0] sout;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    typedef struct {
        logic [15:0] sout;
        int          cyc;
    } exp_t;
    exp_t exp_q[$];

    shift_sequencer dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .in     (in_d),
        .shift  (shift_d),
        .amount (amount_d),
        .busy   (busy),
        .done   (done),
        .sout   (sout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // monitor: every done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("sout", {16'h0000, sout}, {16'h0000, e.sout});
                check("done_cycle", cyc, e.cyc);
            end
        end
    end

    // issue one operation; inject>=0 pulses a stray start at that busy cycle
    task automatic run_op(input logic [15:0] v, input logic [1:0] op, input logic [3:0] amt,
                          input logic [15:0] expv, input int inject);
        int steps;
        int busy_cnt;
        exp_t e;
        steps = ((op == 2'b00) || (amt == 4'd0)) ? 0 : int'(amt);
        e.sout = expv;
        e.cyc  = cyc + 1 + steps;
        exp_q.push_back(e);
        in_d = v; shift_d = op; amount_d = amt; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        in_d = ~v; shift_d = ~op; amount_d = ~amt;
        busy_cnt = 0;
        while (busy === 1'b1 && busy_cnt < 40) begin
            busy_cnt++;
            if (busy_cnt == inject) begin
                start = 1'b1; in_d = 16'h1234; shift_d = 2'b00; amount_d = 4'd0;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        check("busy_cycles", busy_cnt, steps + 1);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        // start held through reset must not be accepted
        in_d = 16'h0005; start = 1'b1;
        repeat (2) @(negedge clk);
        start = 1'b0;
        reset = 1'b0;
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_sout", {16'h0000, sout}, 32'h0000_0000);
        @(negedge clk);
        check("idle_after_reset", {31'd0, busy}, 32'd0);

        run_op(16'h0005, 2'b00, 4'd7, 16'h0005, -1);
        run_op(16'h0002, 2'b01, 4'd3, 16'h0010, -1);
        run_op(16'hE000, 2'b10, 4'd4, 16'h0E00, -1);
        run_op(16'hE000, 2'b11, 4'd4, 16'hFE00, -1);
        run_op(16'h6000, 2'b11, 4'd1, 16'h3000, -1);
        repeat (3) @(negedge clk);
        check("sout_held", {16'h0000, sout}, 32'h0000_3000);
        run_op(16'hFFFF, 2'b01, 4'd15, 16'h8000, 6);
        check("no_rerun_busy", {31'd0, busy}, 32'd0);
        run_op(16'h0001, 2'b10, 4'd0, 16'h0001, -1);

        // reset three cycles into a 10-step shift aborts it silently
        in_d = 16'h0001; shift_d = 2'b01; amount_d = 4'd10; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("abort_started", {31'd0, busy}, 32'd1);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_sout", {16'h0000, sout}, 32'h0000_0000);
        repeat (15) @(negedge clk);
        check("abort_still_idle", {31'd0, busy}, 32'd0);
        check("scoreboard_empty", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
